// File: rtl/fibonacci_calculator.sv
// Iterative Fibonacci engine: start/done handshake, one addition per clock.
// Optional FIB_SATURATE_EN: any overflow during a run forces an all-ones result.
module fibonacci_calculator #(
  parameter int IDX_W  = 5,
  parameter int DATA_W = 16
) (
  input  logic [IDX_W-1:0]  input_s,
  input  logic              reset,
  input  logic              begin_fibo,
  input  logic              clk,
  output logic              done,
  output logic [DATA_W-1:0] fibo_out
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] fibo_q, fibo_d;

`ifdef FIB_SATURATE_EN
  logic              sat_q, sat_d;
  logic [DATA_W:0]   sum;
  assign sum = {1'b0, a_q} + {1'b0, b_q};
`else
  logic [DATA_W-1:0] sum;
  assign sum = a_q + b_q;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    fibo_d  = fibo_q;
`ifdef FIB_SATURATE_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // fibo_out keeps the previous result until the new run finishes
        if (begin_fibo) begin
          a_d     = '0;
          b_d     = DATA_W'(1);
          cnt_d   = input_s;
          done_d  = 1'b0;
          state_d = ST_COMPUTE;
`ifdef FIB_SATURATE_EN
          sat_d   = 1'b0;
`endif
        end
      end
      ST_COMPUTE: begin
        if (cnt_q != '0) begin
          a_d   = b_q;
          b_d   = sum[DATA_W-1:0];
          cnt_d = cnt_q - IDX_W'(1);
`ifdef FIB_SATURATE_EN
          sat_d = sat_q | sum[DATA_W];
`endif
        end else begin
`ifdef FIB_SATURATE_EN
          fibo_d  = sat_q ? '1 : a_q;
`else
          fibo_d  = a_q;
`endif
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      fibo_q  <= '0;
`ifdef FIB_SATURATE_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      fibo_q  <= fibo_d;
`ifdef FIB_SATURATE_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign done     = done_q;
  assign fibo_out = fibo_q;

endmodule

// File: tb/tb_fibonacci_calculator.sv
// Self-checking bench: directed table, sweep, random runs and multi-cycle corners.
module tb_fibonacci_calculator;

  logic        clk = 1'b0;
  logic        reset;
  logic        begin_fibo;
  logic [4:0]  input_s;
  logic        done;
  logic [15:0] fibo_out;

  int n_chk  = 0;
  int n_fail = 0;

  fibonacci_calculator #(.IDX_W(5), .DATA_W(16)) dut (
    .input_s(input_s), .reset(reset), .begin_fibo(begin_fibo),
    .clk(clk), .done(done), .fibo_out(fibo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;
    int exp_val;
  } vec_t;

  // Exact Fibonacci with plain integers; the 16-bit result is derived from it.
  function automatic int fib_exact(input int n);
    int x, y, t;
    x = 0; y = 1;
    for (int i = 0; i < n; i++) begin t = x + y; x = y; y = t; end
    return x;
  endfunction

  function automatic int fib_ref(input int n);
`ifdef FIB_SATURATE_EN
    // the last addition of a run produces F(n+1); it is the largest one
    if (n >= 1 && fib_exact(n + 1) > 65535) return 65535;
`endif
    return fib_exact(n) % 65536;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  // Pulse start, count edges until done; checks latency and result.
  task automatic run(input int n, input int exp_v, input string tag);
    int k;
    logic [15:0] prev;
    @(negedge clk);
    prev = fibo_out;
    input_s = 5'(n); begin_fibo = 1'b1;
    @(negedge clk);
    begin_fibo = 1'b0;
    input_s = 5'($urandom);
    chk({tag, " done low after start"}, int'(done), 0);
    chk({tag, " fibo held after start"}, int'(fibo_out), int'(prev));
    k = 0;
    while (!done && k < 100) begin @(negedge clk); k++; end
    chk({tag, " latency"}, k, n + 1);
    chk({tag, " result"}, int'(fibo_out), exp_v);
  endtask

  vec_t vecs[6];

  initial begin
    int k;
    vecs[0] = '{0, 0};
    vecs[1] = '{1, 1};
    vecs[2] = '{10, 55};
    vecs[3] = '{23, 28657};
    vecs[4] = '{24, 46368};
    vecs[5] = '{25, 9489};

    reset = 1'b1; begin_fibo = 1'b0; input_s = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    chk("reset done", int'(done), 0);
    chk("reset fibo", int'(fibo_out), 0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
`ifdef FIB_SATURATE_EN
      run(vecs[i].n, fib_ref(vecs[i].n), $sformatf("vec n=%0d", vecs[i].n));
`else
      run(vecs[i].n, vecs[i].exp_val, $sformatf("vec n=%0d", vecs[i].n));
`endif
    end

    // DONE holds stable
    repeat (3) @(negedge clk);
    chk("hold done", int'(done), 1);
    chk("hold fibo", int'(fibo_out), fib_ref(25));

    for (int n = 0; n <= 23; n++) begin
      do_reset();
      chk($sformatf("sweep reset n=%0d", n), int'(fibo_out), 0);
      run(n, fib_ref(n), $sformatf("sweep n=%0d", n));
    end

    // back-to-back runs without reset from DONE
    for (int i = 0; i < 20; i++) begin
      int n;
      n = int'($urandom_range(0, 31));
      run(n, fib_ref(n), $sformatf("rand n=%0d", n));
    end

    // reset mid-run aborts, then a fresh run works
    @(negedge clk);
    input_s = 5'd20; begin_fibo = 1'b1;
    @(negedge clk); begin_fibo = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("abort done", int'(done), 0);
    chk("abort fibo", int'(fibo_out), 0);
    repeat (30) @(negedge clk);
    chk("abort stays idle", int'(done), 0);
    run(7, 13, "after abort n=7");

    // start pulse during COMPUTE is ignored
    do_reset();
    @(negedge clk);
    input_s = 5'd15; begin_fibo = 1'b1;
    @(negedge clk); begin_fibo = 1'b0;
    k = 0;
    while (!done && k < 100) begin
      if (k == 3) begin input_s = 5'd3; begin_fibo = 1'b1; end
      else begin_fibo = 1'b0;
      @(negedge clk); k++;
    end
    begin_fibo = 1'b0;
    chk("ignore start latency", k, 16);
    chk("ignore start result", int'(fibo_out), 610);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
